// File: rtl/ps2_mouse_cursor.sv
// PS/2 mouse packet framer and screen-clamped cursor accumulator.
// Optional build macro MOUSE_ACCEL_EN doubles deltas whose magnitude exceeds ACCEL_THRESH.
module ps2_mouse_cursor #(
  parameter int H_MAX          = 639,
  parameter int V_MAX          = 479,
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int ACCEL_THRESH   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stream_en,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic [9:0] cursor_x,
  output logic [9:0] cursor_y,
  output logic [2:0] buttons,
  output logic       packet_valid,
  output logic       sync_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic signed [11:0] HM = 12'(H_MAX);
  localparam logic signed [11:0] VM = 12'(V_MAX);

  typedef enum logic [1:0] {
    BYTE0,
    BYTE1,
    BYTE2,
    UPDATE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    stat_q, stat_d;
  logic [7:0]    xb_q, xb_d;
  logic [7:0]    yb_q, yb_d;
  logic [9:0]    cx_q, cx_d;
  logic [9:0]    cy_q, cy_d;
  logic [2:0]    btn_q, btn_d;
  logic          pv_q, pv_d;
  logic          se_q, se_d;
  logic [1:0]    rsync_q;
  logic          rst_int_n;

  logic signed [11:0] dx, dy, nx, ny;
  logic [9:0]         nx_c, ny_c;

  // Sign-extend, apply overflow masking and optional acceleration.
  function automatic logic signed [11:0] delta(
    input logic       sgn,
    input logic [7:0] b,
    input logic       ovf
  );
    logic signed [9:0] d;
    d = ovf ? 10'sd0 : $signed({sgn, sgn, b});
`ifdef MOUSE_ACCEL_EN
    if (d > $signed(10'(ACCEL_THRESH)) ||
        d < -$signed(10'(ACCEL_THRESH)))
      d = d <<< 1;
`endif
    return {{2{d[9]}}, d};
  endfunction

  // Reset asserts asynchronously, releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsync_q <= 2'b00;
    else        rsync_q <= {rsync_q[0], 1'b1};
  end

  assign rst_int_n = rsync_q[1];

  // New position from latched packet bytes, clamped to the screen.
  always_comb begin
    dx = delta(stat_q[4], xb_q, stat_q[6]);
    dy = delta(stat_q[5], yb_q, stat_q[7]);
    nx = $signed({2'b00, cx_q}) + dx;
    ny = $signed({2'b00, cy_q}) - dy;
    nx_c = nx[9:0];
    ny_c = ny[9:0];
    if (nx < 12'sd0)   nx_c = '0;
    else if (nx > HM)  nx_c = 10'(H_MAX);
    if (ny < 12'sd0)   ny_c = '0;
    else if (ny > VM)  ny_c = 10'(V_MAX);
  end

  // Packet framing, timeout and output update.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    stat_d  = stat_q;
    xb_d    = xb_q;
    yb_d    = yb_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    btn_d   = btn_q;
    pv_d    = 1'b0;
    se_d    = 1'b0;
    if (!stream_en) begin
      state_d = BYTE0;
    end else begin
      unique case (state_q)
        BYTE0: begin
          if (rx_done_tick) begin
            if (rx_data[3]) begin
              stat_d  = rx_data;
              state_d = BYTE1;
            end else begin
              se_d = 1'b1;
            end
          end
        end
        BYTE1: begin
          if (rx_done_tick) begin
            xb_d    = rx_data;
            state_d = BYTE2;
          end else if (cnt_q == CNT_LAST) begin
            state_d = BYTE0;
            se_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        BYTE2: begin
          if (rx_done_tick) begin
            yb_d    = rx_data;
            state_d = UPDATE;
          end else if (cnt_q == CNT_LAST) begin
            state_d = BYTE0;
            se_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        UPDATE: begin
          cx_d    = nx_c;
          cy_d    = ny_c;
          btn_d   = stat_q[2:0];
          pv_d    = 1'b1;
          state_d = BYTE0;
        end
        default: state_d = BYTE0;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= BYTE0;
      cnt_q   <= '0;
      stat_q  <= '0;
      xb_q    <= '0;
      yb_q    <= '0;
      cx_q    <= 10'(H_MAX / 2);
      cy_q    <= 10'(V_MAX / 2);
      btn_q   <= '0;
      pv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stat_q  <= stat_d;
      xb_q    <= xb_d;
      yb_q    <= yb_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      btn_q   <= btn_d;
      pv_q    <= pv_d;
      se_q    <= se_d;
    end
  end

  assign cursor_x     = cx_q;
  assign cursor_y     = cy_q;
  assign buttons      = btn_q;
  assign packet_valid = pv_q;
  assign sync_err     = se_q;

endmodule
